// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions: taps, checker states and
// a saturating increment used by the checker counters.
package prbs_pkg;

    localparam int TAP_HI = 8;
    localparam int TAP_LO = 4;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // Increment v, holding at 2^w - 1 (w up to 64).
    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input int unsigned w
    );
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating event counter with synchronous clear; an
// increment coinciding with clear loads 1.
module prbs_sat_counter
    import prbs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_inc_val;

    assign w_inc_val = CNT_W'(sat_inc(64'(r_cnt), CNT_W));

    // Counter register: clear beats hold, increment beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? CNT_W'(1) : '0;
        end else if (i_inc) begin
            r_cnt <= w_inc_val;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/prbs9_checker.sv
// PRBS9 (x^9 + x^5 + 1) receive checker: self-sync search,
// free-running reference when locked, windowed loss detect.
module prbs9_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int WIN_LEN  = 64,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             lock_lost
);

    localparam int WIN_W = $clog2(WIN_LEN + 1);

    chk_state_e       r_state;
    chk_state_e       w_state_n;
    logic [8:0]       r_sr;
    logic [8:0]       w_sr_n;
    logic [3:0]       r_fill;
    logic [3:0]       w_fill_n;
    logic [7:0]       r_match;
    logic [7:0]       w_match_n;
    logic [WIN_W-1:0] r_wbits;
    logic [WIN_W-1:0] w_wbits_n;
    logic [WIN_W-1:0] r_werr;
    logic [WIN_W-1:0] w_werr_n;
    logic             r_err_pulse;
    logic             w_err_pulse_n;
    logic             r_lock_lost;
    logic             w_lock_lost_n;

    logic             w_pred;
    logic             w_err;
    logic             w_bit_inc;
    logic             w_err_inc;
    logic [WIN_W-1:0] w_wbits_inc;
    logic [WIN_W-1:0] w_werr_inc;

    assign w_pred      = r_sr[TAP_HI] ^ r_sr[TAP_LO];
    assign w_err       = bit_in ^ w_pred;
    assign w_wbits_inc = r_wbits + WIN_W'(1);
    assign w_werr_inc  = r_werr + WIN_W'(w_err);

    // State register plus all datapath state of the checker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SEARCH;
            r_sr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_wbits     <= '0;
            r_werr      <= '0;
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_sr        <= w_sr_n;
            r_fill      <= w_fill_n;
            r_match     <= w_match_n;
            r_wbits     <= w_wbits_n;
            r_werr      <= w_werr_n;
            r_err_pulse <= w_err_pulse_n;
            r_lock_lost <= w_lock_lost_n;
        end
    end

    // Next-state: search fills and matches, locked predicts and counts.
    always_comb begin
        w_state_n     = r_state;
        w_sr_n        = r_sr;
        w_fill_n      = r_fill;
        w_match_n     = r_match;
        w_wbits_n     = r_wbits;
        w_werr_n      = r_werr;
        w_err_pulse_n = 1'b0;
        w_lock_lost_n = 1'b0;
        w_bit_inc     = 1'b0;
        w_err_inc     = 1'b0;
        if (en) begin
            unique case (r_state)
                SEARCH: begin
                    w_sr_n = {r_sr[7:0], bit_in};
                    if (r_fill != 4'd9) begin
                        w_fill_n  = r_fill + 4'd1;
                        w_match_n = '0;
                    end else if (!w_err && (r_sr != '0)) begin
                        w_match_n = r_match + 8'd1;
                        if (r_match == 8'(LOCK_CNT - 1)) begin
                            w_state_n = LOCKED;
                        end
                    end else begin
                        w_match_n = '0;
                    end
                end
                LOCKED: begin
                    w_sr_n        = {r_sr[7:0], w_pred};
                    w_err_pulse_n = w_err;
                    w_bit_inc     = 1'b1;
                    w_err_inc     = w_err;
                    if (w_werr_inc == WIN_W'(LOSS_THR)) begin
                        w_state_n     = SEARCH;
                        w_lock_lost_n = 1'b1;
                        w_fill_n      = '0;
                        w_match_n     = '0;
                        w_wbits_n     = '0;
                        w_werr_n      = '0;
                    end else if (w_wbits_inc == WIN_W'(WIN_LEN)) begin
                        w_wbits_n = '0;
                        w_werr_n  = '0;
                    end else begin
                        w_wbits_n = w_wbits_inc;
                        w_werr_n  = w_werr_inc;
                    end
                end
            endcase
        end
    end

    prbs_sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_err_inc),
        .i_clr (clr_cnt),
        .o_cnt (err_cnt)
    );

    prbs_sat_counter #(
        .CNT_W(CNT_W)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_bit_inc),
        .i_clr (clr_cnt),
        .o_cnt (bit_cnt)
    );

    assign locked    = (r_state == LOCKED);
    assign err_pulse = r_err_pulse;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: lock, errors, loss,
// saturation (CNT_W=4 copy), stuck input, gapped enable, reset.
module tb_prbs9_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        bit_in;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_cnt;
    logic [31:0] bit_cnt;
    logic        lock_lost;
    logic        locked4;
    logic        err_pulse4;
    logic [3:0]  err_cnt4;
    logic [3:0]  bit_cnt4;
    logic        lock_lost4;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pulse;
    int n_lost;
    int n_p4;
    int n_drop;
    int n_drop4;
    int n_high;
    logic [8:0] g;

    always #5 clk = ~clk;

    prbs9_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bit_in    (bit_in),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt),
        .lock_lost (lock_lost)
    );

    prbs9_checker #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bit_in    (bit_in),
        .clr_cnt   (clr_cnt),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_cnt   (err_cnt4),
        .bit_cnt   (bit_cnt4),
        .lock_lost (lock_lost4)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle from a negedge; return at the next negedge.
    task automatic tick(input logic e, input logic b, input logic c);
        en      = e;
        bit_in  = b;
        clr_cnt = c;
        @(negedge clk);
        if (err_pulse)  n_pulse++;
        if (lock_lost)  n_lost++;
        if (err_pulse4) n_p4++;
    endtask

    // Next generator bit: b[n+9] = b[n] ^ b[n+4].
    task automatic send(input logic flip, input logic c);
        logic b;
        b = g[8] ^ g[4];
        g = {g[7:0], b};
        tick(1'b1, b ^ flip, c);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        bit_in  = 1'b0;
        clr_cnt = 1'b0;
        n_pulse = 0;
        n_lost  = 0;
        n_p4    = 0;
        g       = 9'h1AA;
        repeat (3) @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_lost", lock_lost, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_bits", bit_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // clean lock at bit 25
        repeat (24) send(1'b0, 1'b0);
        chk("lock_b24", locked, 0);
        send(1'b0, 1'b0);
        chk("lock_b25", locked, 1);
        n_pulse = 0;
        repeat (1000) send(1'b0, 1'b0);
        chk("clean_err", err_cnt, 0);
        chk("clean_bits", bit_cnt, 1000);
        chk("clean_pulses", n_pulse, 0);
        chk("clean_locked", locked, 1);

        // single error, ends exactly on a window boundary
        send(1'b1, 1'b0);
        chk("single_pulse", err_pulse, 1);
        send(1'b0, 1'b0);
        chk("single_pulse_end", err_pulse, 0);
        repeat (22) send(1'b0, 1'b0);
        chk("single_err", err_cnt, 1);
        chk("single_pulses", n_pulse, 1);
        chk("single_locked", locked, 1);
        chk("single_bits", bit_cnt, 1024);

        // clear on a counted clean bit, then 8 errors in one window
        send(1'b0, 1'b1);
        chk("clr_err", err_cnt, 0);
        chk("clr_bits", bit_cnt, 1);
        n_lost = 0;
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 1'b0);
            if (k == 6) chk("loss_hold7", locked, 1);
            if (k < 7) send(1'b0, 1'b0);
        end
        chk("loss_locked", locked, 0);
        chk("loss_pulse", lock_lost, 1);
        chk("loss_err", err_cnt, 8);
        send(1'b0, 1'b0);
        chk("loss_pulse_end", lock_lost, 0);
        chk("loss_count", n_lost, 1);
        repeat (23) send(1'b0, 1'b0);
        chk("relock_b24", locked, 0);
        send(1'b0, 1'b0);
        chk("relock_b25", locked, 1);
        chk("relock_err", err_cnt, 8);
        chk("relock_bits", bit_cnt, 16);

        // one error per 16 bits: no loss, 4-bit counters saturate
        n_drop  = 0;
        n_drop4 = 0;
        n_p4    = 0;
        for (int i = 0; i < 400; i++) begin
            send((i % 16) == 15, 1'b0);
            if (!locked)  n_drop++;
            if (!locked4) n_drop4++;
        end
        chk("sat_drop", n_drop, 0);
        chk("sat_drop4", n_drop4, 0);
        chk("sat_err4", err_cnt4, 15);
        chk("sat_bits4", bit_cnt4, 15);
        chk("sat_pulses4", n_p4, 25);
        chk("sat_err", err_cnt, 33);
        chk("sat_bits", bit_cnt, 416);

        // clear coinciding with an error bit
        send(1'b1, 1'b1);
        chk("clrerr_err", err_cnt, 1);
        chk("clrerr_bits", bit_cnt, 1);
        chk("clrerr_pulse", err_pulse, 1);

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_pulse", err_pulse, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_bits", bit_cnt, 0);
        chk("arst_err4", err_cnt4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // stuck-at-zero input never locks
        n_high = 0;
        for (int i = 0; i < 500; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (locked) n_high++;
        end
        chk("stuck0_lock", n_high, 0);

        // reset, then gapped enable from a fresh generator
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        g = 9'h1AA;
        for (int i = 0; i < 24; i++) begin
            send(1'b0, 1'b0);
            tick(1'b0, 1'b1, 1'b0);
        end
        chk("gap_b24", locked, 0);
        send(1'b0, 1'b0);
        chk("gap_b25", locked, 1);
        n_pulse = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            send(1'b0, 1'b0);
        end
        chk("gap_bits", bit_cnt, 100);
        chk("gap_err", err_cnt, 0);
        chk("gap_pulses", n_pulse, 0);
        send(1'b1, 1'b0);
        chk("gap_pulse", err_pulse, 1);
        tick(1'b0, 1'b0, 1'b0);
        chk("gap_pulse_idle", err_pulse, 0);
        chk("gap_err1", err_cnt, 1);
        chk("gap_bits1", bit_cnt, 101);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs9_checker.md
Name: prbs9_checker

Overview:
- Receive-side PRBS9 checker. Sits directly downstream of the PRBS9 generator, or after the channel/equaliser path it drives, and consumes one bit per enabled cycle.
- Self-synchronises to the x^9 + x^5 + 1 sequence, declares lock, and then counts bit errors against a free-running local reference.
- Detects loss of lock from the error density and returns to search.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions in SEARCH required to declare lock (range 1..255).
- WIN_LEN, 64: length of the loss-of-lock observation window, in enabled bits (range 2..4096).
- LOSS_THR, 8: errors within one window that force loss of lock (range 1..WIN_LEN).
- CNT_W, 32: width of the error and bit counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  bit_in valid this cycle; all state advances only when en=1
- bit_in  in  1  received PRBS bit
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse, registered, for each bit compared in LOCKED that mismatches
- err_cnt  out  CNT_W  saturating count of mismatches while LOCKED
- bit_cnt  out  CNT_W  saturating count of bits compared while LOCKED
- lock_lost  out  1  one-cycle pulse on each LOCKED->SEARCH transition

Behaviour:
- Reset: state=SEARCH; sr[8:0]=0; fill=0; match=0; window counters=0. Outputs locked, err_pulse, lock_lost, err_cnt and bit_cnt all 0.
- Reference register sr shifts left with the new bit in sr[0]. Predicted bit p = sr[8] ^ sr[4]. This matches generator recurrence b[n+9] = b[n] ^ b[n+4].
- SEARCH:
  - On en: sr <= {sr[7:0], bit_in}.
  - fill counts up to 9. No comparison is made until fill==9.
  - Once fill==9: if bit_in==p and sr!=0, then match++; otherwise match=0.
  - All-zero sr is treated as a mismatch, so a stuck-at-0 input never locks.
  - When the increment makes match==LOCK_CNT: state <= LOCKED and locked=1 from the next cycle.
  - With en continuous and clean input: 9 + LOCK_CNT = 25 bits, and locked rises the cycle after the 25th bit.
  - No errors are counted in SEARCH.
- LOCKED:
  - On en: sr <= {sr[7:0], p}. The reference is free-running, so a single channel error counts once, not three times.
  - err = (bit_in != p). err_pulse = err, registered one cycle after the en cycle.
  - bit_cnt++ on each en; err_cnt++ on each err. Both saturate at 2^CNT_W - 1.
  - Window counters: wbits counts en bits; werr counts errors including the current bit.
  - If werr reaches LOSS_THR: next cycle state=SEARCH, locked=0, lock_lost=1 for one cycle; fill, match and window counters are cleared.
  - Otherwise, on the WIN_LEN-th bit: wbits=0 and werr=0. Windows are fixed and non-overlapping.
  - Counters hold their values across the loss of lock.
- en=0: no state, counter or window change; err_pulse=0.
- clr_cnt:
  - err_cnt and bit_cnt go to 0.
  - If clr_cnt coincides with a counted bit or error, the counter loads 1 (increment wins over the cleared value), not 0.
  - clr_cnt does not affect lock state or the window counters.
- Loss threshold and window end on the same bit: loss of lock takes priority.
- rst_n asserted mid-operation: immediate return to reset values. Relock requires a full 25-bit sequence (defaults).

Decomposition:
- Shared package prbs_pkg:
  - PRBS9 tap constants (TAP_HI=8, TAP_LO=4).
  - Checker state enum {SEARCH, LOCKED}.
  - Saturating-increment function.
  - The generator uses the same package so that taps are defined once.
- One natural sub-module: prbs_sat_counter (CNT_W, inc, clr, with load-1-on-coincidence). Instantiated twice, for err_cnt and bit_cnt.

Test Plan:
- Clean lock:
  - Stimulus: generator (seed 9'h1AA) -> checker, en=1 continuously.
  - Required: locked=1 the cycle after the 25th bit. After 1000 further bits, err_cnt=0, bit_cnt=1000, no err_pulse.
- Single error:
  - Stimulus: while locked, flip one bit.
  - Required: exactly one err_pulse, one cycle after that bit. err_cnt=1. locked stays 1. The following bits match again (no error multiplication).
- Loss of lock:
  - Stimulus: flip 8 bits within one 64-bit window.
  - Required: lock_lost pulses once; locked=0 the cycle after the 8th error; err_cnt=8.
  - Then, with clean input, locked returns 25 bits later and err_cnt still reads 8.
- Sub-threshold density and saturation:
  - Stimulus: CNT_W=4; one error every 16 bits for 400 bits.
  - Required: locked never drops. err_cnt saturates at 15. err_pulse keeps firing.
- Degenerate input and gapped enable:
  - Stimulus: bit_in=0 with en=1 for 500 cycles.
  - Required: locked stays 0.
  - Stimulus: clean PRBS with en toggling 1/0.
  - Required: lock after 25 enabled bits; counts are identical to the continuous case.
- Clear coincidence and async reset:
  - Stimulus: clr_cnt asserted on the cycle an error bit is compared.
  - Required: err_cnt=1 and bit_cnt=1.
  - Stimulus: rst_n pulsed low mid-stream.
  - Required: all outputs 0 immediately; relock after 25 bits.
